// File: rtl/integ_pkg.sv
// Shared fixed-point definitions for the Integrator and its downstream stages.
package integ_pkg;

  localparam int IN_W     = 22;
  localparam int IN_FRAC  = 20;
  localparam int OUT_FRAC = 14;

  // Integrator output sample, sfix22_En20
  typedef logic signed [IN_W-1:0] sfix22_en20_t;

endpackage

// File: rtl/integ_dec_fifo.sv
// Result FIFO behind the decimator; holds the last popped head while empty.
module integ_dec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  last_head;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/integrator_decimator.sv
// Boxcar-averages 2^DEC_LOG2 integrator samples, rounds/saturates to sfix16_En14
// and queues the results behind a valid/ready port.
module integrator_decimator
  import integ_pkg::*;
#(
  parameter int DEC_LOG2   = 3,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    restart,
  input  sfix22_en20_t            In,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat,
  output logic                    ovf,
  input  logic                    clr_ovf
);

  localparam int ACC_W = IN_W + DEC_LOG2;
  // Dividing by N and dropping the extra fraction bits is a single shift
  localparam int SHIFT = DEC_LOG2 + IN_FRAC - OUT_FRAC;
  localparam logic [DEC_LOG2-1:0]  CNT_LAST = '1;
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(2**(SHIFT-1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'(2**(OUT_W-1)-1);
  localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;

  logic signed [ACC_W-1:0] acc;
  logic [DEC_LOG2-1:0]     cnt;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   shifted;
  logic                    clamp_hi;
  logic                    clamp_lo;
  logic signed [OUT_W-1:0] result;
  logic                    win_close;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    drop;

  assign win_close = en && !restart && (cnt == CNT_LAST);

  always_comb begin
    sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(In);
    rounded  = sum + RND_HALF;
    shifted  = rounded >>> SHIFT;
    clamp_hi = (shifted > SAT_MAX);
    clamp_lo = (shifted < SAT_MIN);
    if (clamp_hi) begin
      result = SAT_MAX[OUT_W-1:0];
    end else if (clamp_lo) begin
      result = SAT_MIN[OUT_W-1:0];
    end else begin
      result = shifted[OUT_W-1:0];
    end
  end

  // Restart outranks window close and also discards that cycle's sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (restart) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc + ACC_W'(In);
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pop       = out_valid && out_ready;
  assign push      = win_close;
  assign drop      = push && full && !pop;
  assign out_valid = !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sat <= win_close && (clamp_hi || clamp_lo);
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  integ_dec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (result),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_integrator_decimator.sv
// Directed bench for integrator_decimator: queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_integrator_decimator;

  localparam int DEC_LOG2   = 3;
  localparam int OUT_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int N          = 1 << DEC_LOG2;
  localparam logic signed [21:0] ONE  = 22'sd1048576;
  localparam logic signed [21:0] HALF = 22'sd524288;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic restart;
  logic out_ready;
  logic clr_ovf;
  logic signed [21:0] in_s;
  logic signed [OUT_W-1:0] out_data;
  logic out_valid;
  logic sat;
  logic ovf;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  longint win_sum = 0;
  int win_cnt = 0;
  logic signed [OUT_W-1:0] fifo_m[$];
  logic signed [OUT_W-1:0] last_m = '0;
  bit sat_m = 1'b0;
  bit ovf_m = 1'b0;

  always #5 clk = ~clk;

  integrator_decimator #(
    .DEC_LOG2   (DEC_LOG2),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .restart   (restart),
    .In        (in_s),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Average of the window in real arithmetic, rounded half up to En14, then clamped
  function automatic logic signed [OUT_W-1:0] expected_result(input longint total, output bit clamped);
    real avg;
    longint r;
    avg = real'(total) / real'(N * 64);
    r = longint'($floor(avg + 0.5));
    clamped = 1'b0;
    if (r > 32767) begin
      r = 32767;
      clamped = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      clamped = 1'b1;
    end
    return OUT_W'(r);
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit pop_m;
    bit push_m;
    bit clamped;
    bit dropped;
    logic signed [OUT_W-1:0] res;
    if (!reset_n) begin
      win_sum = 0;
      win_cnt = 0;
      fifo_m.delete();
      last_m = '0;
      sat_m = 1'b0;
      ovf_m = 1'b0;
    end else begin
      pop_m = (fifo_m.size() > 0) && out_ready;
      push_m = 1'b0;
      clamped = 1'b0;
      dropped = 1'b0;
      res = '0;
      if (restart) begin
        win_sum = 0;
        win_cnt = 0;
      end else if (en) begin
        win_sum += longint'(in_s);
        win_cnt++;
        if (win_cnt == N) begin
          res = expected_result(win_sum, clamped);
          push_m = 1'b1;
          win_sum = 0;
          win_cnt = 0;
        end
      end
      if (pop_m) last_m = fifo_m.pop_front();
      if (push_m) begin
        if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(res);
        else dropped = 1'b1;
      end
      if (dropped) ovf_m = 1'b1;
      else if (clr_ovf) ovf_m = 1'b0;
      sat_m = push_m && clamped;
    end
  end

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      check_output("cyc_valid", longint'(out_valid), longint'(fifo_m.size() > 0));
      check_output("cyc_data", longint'(out_data),
                   (fifo_m.size() > 0) ? longint'(fifo_m[0]) : longint'(last_m));
      check_output("cyc_sat", longint'(sat), longint'(sat_m));
      check_output("cyc_ovf", longint'(ovf), longint'(ovf_m));
    end
  end

  task automatic apply_stimulus(input logic e, input logic r, input logic signed [21:0] d,
                                input logic rdy, input logic c, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      en = e;
      restart = r;
      in_s = d;
      out_ready = rdy;
      clr_ovf = c;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    restart = 1'b0;
    in_s = '0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid", longint'(out_valid), 0);
    check_output("rst_data", longint'(out_data), 0);
    check_output("rst_sat", longint'(sat), 0);
    check_output("rst_ovf", longint'(ovf), 0);
    reset_n = 1'b1;
    cmp_en = 1'b1;

    $display("[TB] constant 1.0 input");
    apply_stimulus(1, 0, ONE, 1, 0, 8);
    check_output("t1_valid", longint'(out_valid), 1);
    check_output("t1_data", longint'(out_data), 16384);
    apply_stimulus(1, 0, ONE, 1, 0, 7);
    check_output("t1_gap_valid", longint'(out_valid), 0);
    apply_stimulus(1, 0, ONE, 1, 0, 1);
    check_output("t1_data2", longint'(out_data), 16384);

    $display("[TB] positive saturation");
    apply_stimulus(1, 0, 22'sh1FFFFF, 1, 0, 8);
    check_output("t2_data", longint'(out_data), 32767);
    check_output("t2_sat", longint'(sat), 1);
    apply_stimulus(0, 0, '0, 1, 0, 1);
    check_output("t2_sat_pulse", longint'(sat), 0);

    $display("[TB] negative full scale");
    apply_stimulus(1, 0, 22'sh200000, 1, 0, 8);
    check_output("t3_data", longint'(out_data), -32768);
    check_output("t3_sat", longint'(sat), 0);
    apply_stimulus(0, 0, '0, 1, 0, 1);

    $display("[TB] back-pressure and overflow");
    for (int k = 1; k <= 5; k++) apply_stimulus(1, 0, 22'(k * 262144), 0, 0, 8);
    check_output("t4_ovf", longint'(ovf), 1);
    check_output("t4_head", longint'(out_data), 4096);
    for (int k = 2; k <= 4; k++) begin
      apply_stimulus(0, 0, '0, 1, 0, 1);
      check_output("t4_drain", longint'(out_data), longint'(k * 4096));
    end
    apply_stimulus(0, 0, '0, 1, 0, 1);
    check_output("t4_empty", longint'(out_valid), 0);
    check_output("t4_hold", longint'(out_data), 16384);
    apply_stimulus(0, 0, '0, 1, 1, 1);
    check_output("t4_clr", longint'(ovf), 0);

    $display("[TB] restart mid-window");
    apply_stimulus(1, 0, -ONE, 1, 0, 5);
    apply_stimulus(1, 1, -ONE, 1, 0, 1);
    apply_stimulus(1, 0, ONE, 1, 0, 7);
    check_output("t5_early", longint'(out_valid), 0);
    apply_stimulus(1, 0, ONE, 1, 0, 1);
    check_output("t5_valid", longint'(out_valid), 1);
    check_output("t5_data", longint'(out_data), 16384);
    apply_stimulus(0, 0, '0, 1, 0, 1);

    $display("[TB] en toggling");
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        apply_stimulus(1, 0, HALF, 0, 0, 1);
        apply_stimulus(0, 0, HALF, 0, 0, 1);
      end
      check_output("t6_valid", longint'(out_valid), 1);
      check_output("t6_data", longint'(out_data), 8192);
    end

    $display("[TB] async reset with queued results");
    apply_stimulus(1, 0, HALF, 0, 0, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("t7_valid", longint'(out_valid), 0);
    check_output("t7_data", longint'(out_data), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply_stimulus(0, 0, '0, 1, 0, 10);
    check_output("t7_stale", longint'(out_valid), 0);
    apply_stimulus(1, 0, ONE, 1, 0, 8);
    check_output("t7_fresh", longint'(out_data), 16384);

    cmp_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
